// File: rtl/pulse_gen_prog.sv
// Programmable tick / pulse generator.
// Produces a single-cycle tick at the start of every period and a pulse of
// programmable width that begins with the tick. Runs either as a free-running
// clock-enable (periodic) or as a start-triggered one-shot. Period, width and
// mode are only taken from the inputs while disabled or at period boundaries,
// so changing them mid-period never shortens or glitches the current period.
module pulse_gen_prog #(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             start,
   input  logic [CNT_W-1:0] div,
   input  logic [CNT_W-1:0] width,
   output logic             tick,
   output logic             pulse,
   output logic             busy,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // A programmed period of 0 behaves as a period of 1.
   function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] d);
      return (d == '0) ? ONE : d;
   endfunction

   // Pulse width is clamped to the period so W >= P gives a solid high.
   function automatic logic [CNT_W-1:0] eff_width(input logic [CNT_W-1:0] w,
                                                  input logic [CNT_W-1:0] p);
      return (w < p) ? w : p;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic             mode_q, mode_d;
   logic             wrapped_q, wrapped_d;
   logic             tick_q, tick_d;
   logic             pulse_q, pulse_d;
   logic             busy_q, busy_d;
   logic             at_end;

   // Last cycle of the current period (cnt has reached P-1).
   assign at_end = (cnt_q == (eff_period(div_q) - ONE));

   // State register; reset overrides enable and start.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         div_q     <= DIV_RST;
         width_q   <= '0;
         mode_q    <= 1'b0;
         wrapped_q <= 1'b0;
         tick_q    <= 1'b0;
         pulse_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         width_q   <= width_d;
         mode_q    <= mode_d;
         wrapped_q <= wrapped_d;
         tick_q    <= tick_d;
         pulse_q   <= pulse_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state and registered-output logic for idle, periodic and one-shot operation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      width_d   = width_q;
      mode_d    = mode_q;
      wrapped_d = wrapped_q;
      tick_d    = 1'b0;
      pulse_d   = 1'b0;
      busy_d    = 1'b0;

      if (!en) begin
         // Disabled: clear the phase and accept new configuration.
         state_d   = S_IDLE;
         cnt_d     = '0;
         wrapped_d = 1'b0;
         mode_d    = mode;
         div_d     = div;
         width_d   = width;
      end else if (!mode_q) begin
         // Periodic: count 0..P-1, reloading configuration at each wrap.
         state_d = S_IDLE;
         busy_d  = 1'b1;
         if (at_end) begin
            cnt_d     = '0;
            wrapped_d = 1'b1;
            div_d     = div;
            width_d   = width;
            tick_d    = 1'b1;
         end else begin
            cnt_d = cnt_q + ONE;
         end
         pulse_d = wrapped_d && (cnt_d < eff_width(width_d, eff_period(div_d)));
      end else begin
         // One-shot: a start in IDLE launches exactly one period.
         wrapped_d = 1'b0;
         unique case (state_q)
            S_IDLE: begin
               cnt_d = '0;
               if (start) begin
                  state_d = S_RUN;
                  div_d   = div;
                  width_d = width;
                  tick_d  = 1'b1;
                  busy_d  = 1'b1;
               end
            end
            S_RUN: begin
               if (at_end) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d  = cnt_q + ONE;
                  busy_d = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
         pulse_d = (state_d == S_RUN) &&
                   (cnt_d < eff_width(width_d, eff_period(div_d)));
      end
   end

   assign tick  = tick_q;
   assign pulse = pulse_q;
   assign busy  = busy_q;
   assign cnt_o = cnt_q;

endmodule

// File: tb/tb_pulse_gen_prog.sv
// Directed bench for pulse_gen_prog: legacy divide-by-4, period change,
// one-shot, boundaries, abort/reset and mode-change behaviour.
module tb_pulse_gen_prog;

   logic       clk;
   logic       rst;
   logic       en;
   logic       mode;
   logic       start;
   logic [7:0] div;
   logic [7:0] width;
   logic       tick;
   logic       pulse;
   logic       busy;
   logic [7:0] cnt_o;

   int vecs;
   int miscompares;

   // Hand-computed cnt_o sequence for the period-change scenario (5 -> 3).
   logic [7:0] t2_cnt [17] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0,
                               8'd1, 8'd2, 8'd3, 8'd4, 8'd0,
                               8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1};

   pulse_gen_prog #(
      .CNT_W       (8),
      .DEFAULT_DIV (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .start (start),
      .div   (div),
      .width (width),
      .tick  (tick),
      .pulse (pulse),
      .busy  (busy),
      .cnt_o (cnt_o)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then compare all outputs 1 ns later.
   task automatic step(input string tag, input logic et, input logic ep,
                       input logic eb, input logic [7:0] ec);
      @(posedge clk);
      #1;
      vecs++;
      assert (tick === et) else begin
         miscompares++;
         $error("FAIL %s tick: observed %b expected %b", tag, tick, et);
      end
      vecs++;
      assert (pulse === ep) else begin
         miscompares++;
         $error("FAIL %s pulse: observed %b expected %b", tag, pulse, ep);
      end
      vecs++;
      assert (busy === eb) else begin
         miscompares++;
         $error("FAIL %s busy: observed %b expected %b", tag, busy, eb);
      end
      vecs++;
      assert (cnt_o === ec) else begin
         miscompares++;
         $error("FAIL %s cnt_o: observed %0d expected %0d", tag, cnt_o, ec);
      end
   endtask

   initial begin
      vecs        = 0;
      miscompares = 0;
      clk   = 1'b0;
      rst   = 1'b0;
      en    = 1'b0;
      mode  = 1'b0;
      start = 1'b0;
      div   = 8'd4;
      width = 8'd1;

      // Reset state
      step("reset", 1'b0, 1'b0, 1'b0, 8'd0);

      // 1: legacy divide-by-4
      rst = 1'b1;
      en  = 1'b1;
      for (int n = 1; n <= 12; n++)
         step($sformatf("div4 n=%0d", n), (n % 4) == 0, (n % 4) == 0, 1'b1, 8'(n % 4));

      // 2: periodic div=5 width=2, div changed to 3 after edge 7
      en    = 1'b0;
      div   = 8'd5;
      width = 8'd2;
      step("t2 disable", 1'b0, 1'b0, 1'b0, 8'd0);
      en = 1'b1;
      for (int n = 1; n <= 17; n++) begin
         step($sformatf("t2 n=%0d", n), t2_cnt[n-1] == 8'd0,
              (n >= 5) && (t2_cnt[n-1] < 8'd2), 1'b1, t2_cnt[n-1]);
         if (n == 7) div = 8'd3;
      end

      // 3: one-shot div=6 width=3, start re-asserted at s+2 ignored
      en    = 1'b0;
      mode  = 1'b1;
      div   = 8'd6;
      width = 8'd3;
      step("t3 disable", 1'b0, 1'b0, 1'b0, 8'd0);
      en = 1'b1;
      step("t3 idle", 1'b0, 1'b0, 1'b0, 8'd0);
      start = 1'b1;
      step("t3 s", 1'b1, 1'b1, 1'b1, 8'd0);
      start = 1'b0;
      step("t3 s+1", 1'b0, 1'b1, 1'b1, 8'd1);
      start = 1'b1;
      step("t3 s+2", 1'b0, 1'b1, 1'b1, 8'd2);
      start = 1'b0;
      step("t3 s+3", 1'b0, 1'b0, 1'b1, 8'd3);
      step("t3 s+4", 1'b0, 1'b0, 1'b1, 8'd4);
      step("t3 s+5", 1'b0, 1'b0, 1'b1, 8'd5);
      step("t3 s+6", 1'b0, 1'b0, 1'b0, 8'd0);
      step("t3 s+7", 1'b0, 1'b0, 1'b0, 8'd0);

      // 5a: abort a running one-shot by dropping en
      start = 1'b1;
      step("abort s", 1'b1, 1'b1, 1'b1, 8'd0);
      start = 1'b0;
      step("abort s+1", 1'b0, 1'b1, 1'b1, 8'd1);
      step("abort s+2", 1'b0, 1'b1, 1'b1, 8'd2);
      en = 1'b0;
      step("abort off", 1'b0, 1'b0, 1'b0, 8'd0);

      // Held start: back-to-back shots separated by one idle cycle
      en    = 1'b1;
      start = 1'b1;
      step("held s", 1'b1, 1'b1, 1'b1, 8'd0);
      step("held s+1", 1'b0, 1'b1, 1'b1, 8'd1);
      step("held s+2", 1'b0, 1'b1, 1'b1, 8'd2);
      step("held s+3", 1'b0, 1'b0, 1'b1, 8'd3);
      step("held s+4", 1'b0, 1'b0, 1'b1, 8'd4);
      step("held s+5", 1'b0, 1'b0, 1'b1, 8'd5);
      step("held gap", 1'b0, 1'b0, 1'b0, 8'd0);
      step("held s2", 1'b1, 1'b1, 1'b1, 8'd0);
      start = 1'b0;

      // 4: div=0 then div=1 periodic -> continuous tick and pulse
      en    = 1'b0;
      mode  = 1'b0;
      div   = 8'd0;
      width = 8'd1;
      step("div0 disable", 1'b0, 1'b0, 1'b0, 8'd0);
      en = 1'b1;
      for (int n = 1; n <= 3; n++)
         step($sformatf("div0 n=%0d", n), 1'b1, 1'b1, 1'b1, 8'd0);
      div = 8'd1;
      for (int n = 4; n <= 6; n++)
         step($sformatf("div1 n=%0d", n), 1'b1, 1'b1, 1'b1, 8'd0);

      // 4: width=0 -> no pulse, ticks every 4
      en    = 1'b0;
      div   = 8'd4;
      width = 8'd0;
      step("w0 disable", 1'b0, 1'b0, 1'b0, 8'd0);
      en = 1'b1;
      for (int n = 1; n <= 8; n++)
         step($sformatf("w0 n=%0d", n), (n % 4) == 0, 1'b0, 1'b1, 8'(n % 4));

      // 4: width=9 div=4 -> pulse solid after first wrap
      en    = 1'b0;
      width = 8'd9;
      step("w9 disable", 1'b0, 1'b0, 1'b0, 8'd0);
      en = 1'b1;
      for (int n = 1; n <= 8; n++)
         step($sformatf("w9 n=%0d", n), (n % 4) == 0, n >= 4, 1'b1, 8'(n % 4));

      // 5b: reset mid-period restores DEFAULT_DIV (input div=3 ignored until wrap)
      en    = 1'b0;
      div   = 8'd3;
      width = 8'd1;
      step("rst disable", 1'b0, 1'b0, 1'b0, 8'd0);
      en = 1'b1;
      step("rst n=1", 1'b0, 1'b0, 1'b1, 8'd1);
      step("rst n=2", 1'b0, 1'b0, 1'b1, 8'd2);
      rst = 1'b0;
      step("rst mid", 1'b0, 1'b0, 1'b0, 8'd0);
      rst = 1'b1;
      step("post-rst n=1", 1'b0, 1'b0, 1'b1, 8'd1);
      step("post-rst n=2", 1'b0, 1'b0, 1'b1, 8'd2);
      step("post-rst n=3", 1'b0, 1'b0, 1'b1, 8'd3);
      step("post-rst n=4", 1'b1, 1'b1, 1'b1, 8'd0);
      step("post-rst n=5", 1'b0, 1'b0, 1'b1, 8'd1);
      step("post-rst n=6", 1'b0, 1'b0, 1'b1, 8'd2);
      step("post-rst n=7", 1'b1, 1'b1, 1'b1, 8'd0);

      // 6: mode flipped to one-shot while running stays periodic until en drops
      mode = 1'b1;
      step("mode n=8", 1'b0, 1'b0, 1'b1, 8'd1);
      step("mode n=9", 1'b0, 1'b0, 1'b1, 8'd2);
      step("mode n=10", 1'b1, 1'b1, 1'b1, 8'd0);
      en = 1'b0;
      step("mode disable", 1'b0, 1'b0, 1'b0, 8'd0);
      en = 1'b1;
      step("mode idle", 1'b0, 1'b0, 1'b0, 8'd0);
      start = 1'b1;
      step("mode s", 1'b1, 1'b1, 1'b1, 8'd0);
      start = 1'b0;
      step("mode s+1", 1'b0, 1'b0, 1'b1, 8'd1);
      step("mode s+2", 1'b0, 1'b0, 1'b1, 8'd2);
      step("mode s+3", 1'b0, 1'b0, 1'b0, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule

// File: doc/pulse_gen_prog.md
Name: pulse_gen_prog

Overview:
Parametrised, programmable successor to the fixed divide-by-4 pulse generator. Produces a single-cycle tick and a programmable-width pulse at a runtime-selected period. Supports periodic (free-running clock-enable) and one-shot modes. Used as the common timebase/strobe source for VGA pixel enable, paddle/ball update rate and sound timers.

Parameters:
CNT_W, 8, width of period/width/counter fields
DEFAULT_DIV, 4, period loaded into div_q at reset (must be 1..2^CNT_W-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk)
en  in  1  block enable; 0 = idle/abort
mode  in  1  0 = periodic, 1 = one-shot
start  in  1  one-shot trigger (ignored in periodic mode)
div  in  CNT_W  period P in cycles; 0 treated as 1
width  in  CNT_W  pulse high width W in cycles
tick  out  1  single-cycle strobe at period start
pulse  out  1  W-cycle high pulse starting with tick
busy  out  1  one-shot in progress / periodic running
cnt_o  out  CNT_W  current phase counter

Behaviour:
- All outputs registered; all state updates on rising clk only.
- Reset (rst=0): cnt=0, div_q=DEFAULT_DIV, width_q=0, mode_q=0, wrapped=0, tick=0, pulse=0, busy=0, cnt_o=0. Reset overrides en/start, including mid-period.
- Effective period P = max(div_q,1); effective width We = min(width_q,P).
- en=0 on an edge: cnt<=0, wrapped<=0, tick/pulse/busy<=0; mode_q, div_q, width_q load from inputs. Aborts any running one-shot.
- mode_q, div_q and width_q never change while en=1, except at the reload points listed below. No glitching on mid-period changes.
- Periodic (mode_q=0, en=1):
  - Edges are numbered n=1,2,... from the first edge with en=1.
  - After edge n: cnt = n mod P; busy=1.
  - When cnt==P-1 before an edge, that edge sets cnt<=0 and wrapped<=1, and reloads div_q/width_q from the inputs. The new values apply from the next period.
  - tick high after edge n iff n≥P and n mod P==0, i.e. one cycle every P cycles. The first tick comes P cycles after enable.
  - pulse high iff wrapped=1 and cnt<We. The pulse is coincident with tick for its first cycle.
  - P=1: tick and pulse (if W≥1) are held high continuously from edge 1.
- One-shot (mode_q=1, en=1):
  - States: IDLE, RUN.
  - IDLE: busy=0, tick=0, pulse=0, cnt=0.
  - start=1 sampled in IDLE at edge s: div_q/width_q reload, state<=RUN, busy<=1, cnt<=0, tick<=1 (after edge s only). pulse is high after edges s..s+We-1.
  - RUN: cnt increments each edge. At the edge where cnt==P-1, state<=IDLE, busy<=0, cnt<=0. busy is therefore high for exactly P cycles.
  - start while RUN is ignored (no retrigger). start held high continuously gives back-to-back shots with one IDLE cycle between them.
- W=0 gives no pulse ever; tick is unaffected. W≥P means pulse is high for the whole period (continuous in periodic mode).
- cnt_o = cnt at all times.
- Wrap: cnt never exceeds P-1. Arithmetic is CNT_W-bit unsigned with no overflow, since P≤2^CNT_W-1.

Test Plan:
1. Reset with DEFAULT_DIV=4, div=4, width=1, mode=0, then en=1 -> tick/pulse high after edges 4,8,12 only; cnt_o sequence 1,2,3,0,1,...; busy=1 from edge 1. This is the legacy divide-by-4 equivalence.
2. Periodic div=5, width=2, then div changed to 3 after edge 7 -> ticks at edges 5 and 10. The new period applies after the edge-10 reload, giving ticks at 13 and 16. pulse is high at edges 5,6 and 10,11.
3. One-shot div=6, width=3, start pulse at edge s -> tick only after s; pulse after s..s+2; busy after s..s+5. A start re-asserted at s+2 is ignored.
4. Boundaries: div=0 and div=1 periodic -> tick continuously high from edge 1. width=0 -> pulse never high. width=9 with div=4 -> pulse continuously high after the first wrap.
5. Abort and reset: en dropped mid one-shot at s+2 -> all outputs 0 and cnt_o=0 after the next edge. rst=0 asserted mid-period in periodic mode -> all outputs 0 after that edge, and div_q returns to DEFAULT_DIV.
6. Mode change with en=1 (0->1 mid-run) -> no effect until en is low for one edge; then one-shot behaviour follows from the next start.
